ooc_stim_harness: RTL and testbench
===================================

// Module: ooc_stim_harness
// PURPOSE
//  Parametrised random-stimulus and response-signature wrapper for out-of-context designs under test (DUTs).
//  - Stimulus: a 32-bit LFSR fills an IN_W-bit input bus word by word, then runs start/done handshakes with the DUT.
//  - Response: the DUT output bus is folded into a 32-bit MISR, so no DUT logic is pruned at implementation.
//  - Replaces per-design wrappers; gives repeatable runs that are compared by signature.
// PARAMETERS
//  IN_W     392          width of the DUT stimulus bus (>=1)
//  OUT_W    392          width of the DUT response bus (>=1)
//  SEED     32'h00000001 LFSR reset value; a value of 0 is replaced by 1
//  TIMEOUT  1024         maximum WAIT cycles before a run is aborted (>=1)
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      asynchronous reset, active-low
//  en_i         in   1      level; keeps launching runs while high
//  dut_in_o     out  IN_W   stimulus to DUT; stable from START through CAPTURE
//  dut_start_o  out  1      one-cycle start pulse to DUT (registered)
//  dut_done_i   in   1      DUT completion; sampled only in WAIT
//  dut_out_i    in   OUT_W  DUT response; sampled in CAPTURE
//  sig_o        out  32     MISR signature
//  run_cnt_o    out  16     completed runs; wraps 0xFFFF->0
//  timeout_o    out  1      sticky; set when any run times out
//  busy_o       out  1      high in every state except IDLE
// BEHAVIOUR
//  Reset (async assert, sync release) drives these values:
//  - lfsr=SEED (or 1 if SEED==0); dut_in_o=0; dut_start_o=0; sig_o=0; run_cnt_o=0; timeout_o=0; busy_o=0.
//  - FSM enters IDLE; wait counter=0.
//  - Reset mid-run abandons the run immediately; no partial capture is made.
//  LFSR: lfsr_n = (lfsr<<1) ^ (lfsr[31] ? 32'h0040_0007 : 0)  (x^32+x^22+x^2+x+1).
//  - Advances only in LOAD, once per cycle.
//  WORDS = ceil(IN_W/32).
//  FSM (all transitions registered):
//  - IDLE: en_i=1 -> LOAD.
//  - LOAD: lasts exactly WORDS cycles.
//    - Each cycle: dut_in_o <= {dut_in_o, lfsr}[IN_W-1:0] (new word in the LSBs), then lfsr advances.
//    - After the last word -> START.
//  - START: one cycle; dut_start_o=1 in this cycle only -> WAIT.
//    - dut_done_i is ignored here.
//  - WAIT: the wait counter increments each cycle.
//    - dut_done_i=1 -> CAPTURE.
//    - Counter reaches TIMEOUT with no done -> timeout_o<=1, then CAPTURE.
//    - If both occur in the same cycle, done wins and timeout_o is not set.
//  - CAPTURE: one cycle.
//    - fold = XOR of the 32-bit slices of dut_out_i (the last slice is zero-padded).
//    - sig_o <= (sig_o<<1) ^ (sig_o[31] ? 32'h0040_0007 : 0) ^ fold.
//    - run_cnt_o++ (wraps); wait counter cleared.
//    - Next state: en_i=1 -> LOAD, else IDLE.
//  en_i low mid-run: the current run completes through CAPTURE, then the FSM goes to IDLE.
//  - A pulse on en_i shorter than one run still yields exactly one run.
//  Latency: en_i rising in IDLE -> dut_start_o high after WORDS+1 clocks (LOAD occupies WORDS cycles).
//  dut_in_o holds its last value in IDLE.
//  sig_o and timeout_o are cleared only by reset.
// TESTING
//  1. IN_W=64, SEED=1, en_i pulsed 1 cycle.
//     -> dut_in_o=64'h00000001_00000002; one dut_start_o pulse; run_cnt_o=1 after done; back to IDLE.
//  2. SEED=0 -> behaves identically to SEED=1.
//     LFSR after 32 steps from 1 = 32'h0040_0007.
//  3. en_i held high; DUT asserts done 3 cycles after start.
//     -> back-to-back runs with period WORDS+5 cycles.
//     -> run_cnt_o wraps 0xFFFF->0 (force the count).
//  4. TIMEOUT=8, DUT never asserts done -> CAPTURE 8 cycles after WAIT entry; timeout_o=1 and stays set.
//     Variant: done in the same cycle the counter reaches TIMEOUT -> timeout_o stays 0.
//  5. OUT_W=40, dut_out_i=40'hFF_00000001, sig_o=0.
//     -> after CAPTURE sig_o=32'h000000FE.
//     Second capture of the same value -> sig_o=32'h00000102.
//  6. rst asserted in WAIT -> all outputs reset immediately (asynchronously).
//     -> no spurious dut_start_o; the run restarts from SEED when en_i is seen high.

Source files
------------

// File: rtl/ooc_stim_harness.sv
`default_nettype none
// ============================================================================
// Module   : ooc_stim_harness
// Purpose  : Random-stimulus / response-signature wrapper for an
//            out-of-context DUT. A 32-bit LFSR fills the DUT input bus one
//            word at a time, the harness pulses start, waits for done (or a
//            timeout), and folds the DUT output bus into a 32-bit MISR. The
//            MISR keeps every DUT output observable, so implementation cannot
//            prune DUT logic, and runs can be compared by signature.
// Ports    : clk          in   1      rising-edge clock
//            rst          in   1      asynchronous reset, active-low
//            en_i         in   1      keep launching runs while high
//            dut_in_o     out  IN_W   stimulus bus (stable START..CAPTURE)
//            dut_start_o  out  1      one-cycle start pulse
//            dut_done_i   in   1      DUT completion, sampled in WAIT only
//            dut_out_i    in   OUT_W  DUT response, sampled in CAPTURE
//            sig_o        out  32     MISR signature
//            run_cnt_o    out  16     completed runs (wraps)
//            timeout_o    out  1      sticky run-timeout flag
//            busy_o       out  1      high whenever not IDLE
// Revision : 1.0 - initial release
// ============================================================================
module ooc_stim_harness #(
    parameter int          IN_W    = 392,
    parameter int          OUT_W   = 392,
    parameter logic [31:0] SEED    = 32'h0000_0001,
    parameter int          TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [IN_W-1:0]  dut_in_o,
    output logic             dut_start_o,
    input  logic             dut_done_i,
    input  logic [OUT_W-1:0] dut_out_i,
    output logic [31:0]      sig_o,
    output logic [15:0]      run_cnt_o,
    output logic             timeout_o,
    output logic             busy_o
);

    localparam int          WORDS     = (IN_W + 31) / 32;
    localparam int          OWORDS    = (OUT_W + 31) / 32;
    localparam int          WC_W      = $clog2(WORDS + 1);
    localparam int          TC_W      = $clog2(TIMEOUT + 1);
    localparam logic [31:0] POLY      = 32'h0040_0007;
    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [31:0] LFSR_INIT = (SEED == 32'd0) ? 32'd1 : SEED;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_START   = 3'd2,
        S_WAIT    = 3'd3,
        S_CAPTURE = 3'd4
    } state_t;

    state_t            state_q,    state_d;
    logic [31:0]       lfsr_q,     lfsr_d;
    logic [IN_W-1:0]   dut_in_q,   dut_in_d;
    logic              start_q,    start_d;
    logic [31:0]       sig_q,      sig_d;
    logic [15:0]       run_cnt_q,  run_cnt_d;
    logic              timeout_q,  timeout_d;
    logic              busy_q,     busy_d;
    logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
    logic [TC_W-1:0]   wait_cnt_q, wait_cnt_d;

    logic [IN_W-1:0]       shifted_w;
    logic [OWORDS*32-1:0]  out_pad_w;
    logic [31:0]           fold_w;
    logic [TC_W-1:0]       wait_inc_w;

    // Galois step shared by the stimulus LFSR and the MISR.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return {v[30:0], 1'b0} ^ (v[31] ? POLY : 32'd0);
    endfunction

    // New LFSR word enters at the LSBs; older words move up and the oldest
    // bits fall off the top of the bus.
    generate
        if (IN_W > 32) begin : g_wide_bus
            assign shifted_w = {dut_in_q[IN_W-33:0], lfsr_q};
        end else begin : g_narrow_bus
            assign shifted_w = lfsr_q[IN_W-1:0];
        end
    endgenerate

    // XOR of all 32-bit slices of the response, last slice zero-padded.
    always_comb begin
        out_pad_w            = '0;
        out_pad_w[OUT_W-1:0] = dut_out_i;
        fold_w               = '0;
        for (int i = 0; i < OWORDS; i++) begin
            fold_w = fold_w ^ out_pad_w[i*32 +: 32];
        end
    end

    assign wait_inc_w = wait_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        dut_in_d   = dut_in_q;
        sig_d      = sig_q;
        run_cnt_d  = run_cnt_q;
        timeout_d  = timeout_q;
        word_cnt_d = word_cnt_q;
        wait_cnt_d = wait_cnt_q;

        case (state_q)
            S_IDLE: begin
                word_cnt_d = '0;
                if (en_i) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                dut_in_d = shifted_w;
                lfsr_d   = lfsr_step(lfsr_q);
                if (word_cnt_q == WC_W'(WORDS - 1)) begin
                    word_cnt_d = '0;
                    state_d    = S_START;
                end else begin
                    word_cnt_d = word_cnt_q + 1'b1;
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wait_cnt_d = wait_inc_w;
                // done has priority: a run finishing on the limit cycle is
                // not a timeout.
                if (dut_done_i) begin
                    state_d = S_CAPTURE;
                end else if (wait_inc_w == TC_W'(TIMEOUT)) begin
                    timeout_d = 1'b1;
                    state_d   = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                sig_d      = lfsr_step(sig_q) ^ fold_w;
                run_cnt_d  = run_cnt_q + 16'd1;
                wait_cnt_d = '0;
                state_d    = en_i ? S_LOAD : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Start and busy are registered from the next state so they are clean
    // flop outputs aligned with the state they describe.
    assign start_d = (state_d == S_START);
    assign busy_d  = (state_d != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            lfsr_q     <= LFSR_INIT;
            dut_in_q   <= '0;
            start_q    <= 1'b0;
            sig_q      <= '0;
            run_cnt_q  <= '0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
            word_cnt_q <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            dut_in_q   <= dut_in_d;
            start_q    <= start_d;
            sig_q      <= sig_d;
            run_cnt_q  <= run_cnt_d;
            timeout_q  <= timeout_d;
            busy_q     <= busy_d;
            word_cnt_q <= word_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign dut_in_o    = dut_in_q;
    assign dut_start_o = start_q;
    assign sig_o       = sig_q;
    assign run_cnt_o   = run_cnt_q;
    assign timeout_o   = timeout_q;
    assign busy_o      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ooc_stim_harness.sv
`default_nettype none
// ============================================================================
// Module   : tb_ooc_stim_harness
// Purpose  : Self-checking bench for ooc_stim_harness. Two instances run
//            side by side (SEED=1 and SEED=0, which must behave identically)
//            with IN_W=64, OUT_W=40, TIMEOUT=8. A run-level reference model
//            predicts every output each cycle; directed scenarios add
//            hand-computed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ooc_stim_harness;

    localparam int          IN_W    = 64;
    localparam int          OUT_W   = 40;
    localparam int          TIMEOUT = 8;
    localparam int          WORDS   = 2;
    localparam logic [31:0] POLY    = 32'h0040_0007;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             done;
    logic [OUT_W-1:0] dut_out;

    logic [IN_W-1:0] in0, in1;
    logic            st0, st1, to0, to1, busy0, busy1;
    logic [31:0]     sig0, sig1;
    logic [15:0]     cnt0, cnt1;

    always #5 clk = ~clk;

    ooc_stim_harness #(.IN_W(IN_W), .OUT_W(OUT_W), .SEED(32'h1), .TIMEOUT(TIMEOUT)) dut0 (
        .clk(clk), .rst(rst), .en_i(en), .dut_in_o(in0), .dut_start_o(st0),
        .dut_done_i(done), .dut_out_i(dut_out), .sig_o(sig0), .run_cnt_o(cnt0),
        .timeout_o(to0), .busy_o(busy0));

    ooc_stim_harness #(.IN_W(IN_W), .OUT_W(OUT_W), .SEED(32'h0), .TIMEOUT(TIMEOUT)) dut1 (
        .clk(clk), .rst(rst), .en_i(en), .dut_in_o(in1), .dut_start_o(st1),
        .dut_done_i(done), .dut_out_i(dut_out), .sig_o(sig1), .run_cnt_o(cnt1),
        .timeout_o(to1), .busy_o(busy1));

    int vecs = 0;
    int miss = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (run-level view) ----------------
    // m_t counts cycles since the run began: 0..WORDS-1 loading, WORDS is
    // the start cycle, beyond that waiting until the capture cycle (m_cap).
    bit          m_active, m_cap, m_to;
    int          m_t, m_wait;
    logic [31:0] m_lfsr, m_sig;
    logic [63:0] m_in;
    logic [15:0] m_cnt;

    function automatic logic [31:0] fold40(input logic [39:0] v);
        return v[31:0] ^ {24'd0, v[39:32]};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active = 0; m_cap = 0; m_to = 0; m_t = 0; m_wait = 0;
            m_lfsr = 32'd1; m_sig = 32'd0; m_in = 64'd0; m_cnt = 16'd0;
        end else if (!m_active) begin
            if (en) begin
                m_active = 1; m_t = 0; m_cap = 0;
            end
        end else if (m_cap) begin
            m_sig    = {m_sig[30:0], 1'b0} ^ (m_sig[31] ? POLY : 32'd0) ^ fold40(dut_out);
            m_cnt    = m_cnt + 16'd1;
            m_cap    = 0;
            m_t      = 0;
            m_active = en;
        end else if (m_t < WORDS) begin
            m_in   = {m_in[31:0], m_lfsr};
            m_lfsr = {m_lfsr[30:0], 1'b0} ^ (m_lfsr[31] ? POLY : 32'd0);
            m_t++;
        end else if (m_t == WORDS) begin
            m_t++;
            m_wait = 0;
        end else begin
            m_wait++;
            if (done) begin
                m_cap = 1;
            end else if (m_wait == TIMEOUT) begin
                m_to  = 1;
                m_cap = 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic exp_start;
        exp_start = m_active && !m_cap && (m_t == WORDS);
        chk("d0 dut_in",  in0,   m_in);
        chk("d0 start",   st0,   exp_start);
        chk("d0 sig",     sig0,  m_sig);
        chk("d0 run_cnt", cnt0,  m_cnt);
        chk("d0 timeout", to0,   m_to);
        chk("d0 busy",    busy0, m_active);
        chk("d1 dut_in",  in1,   m_in);
        chk("d1 start",   st1,   exp_start);
        chk("d1 sig",     sig1,  m_sig);
        chk("d1 run_cnt", cnt1,  m_cnt);
        chk("d1 timeout", to1,   m_to);
        chk("d1 busy",    busy1, m_active);
    end

    // ---------------- DUT responder ----------------
    // done_delay: cycles after the start cycle that done is high;
    // -1 = never, 99 = held high permanently.
    int  done_delay = -1;
    int  sc = 1000;
    int  nstarts = 0;
    time t_start = 0;
    time period = 0;

    always @(negedge clk) begin
        if (st0) begin
            sc = 0;
            nstarts++;
            period  = $time - t_start;
            t_start = $time;
        end else if (sc < 1000) begin
            sc++;
        end
        done = (done_delay == 99) ? 1'b1 : (sc == done_delay);
    end

    time t_idle;

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        @(negedge clk);
        while (busy0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        t_idle = $time;
        chk("idle within budget", busy0, 1'b0);
    endtask

    task automatic pulse_en();
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
    endtask

    initial begin
        int k;
        int s_before;
        rst = 1'b0; en = 1'b0; dut_out = '0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("reset sig", sig0, 32'd0);
        chk("reset dut_in", in0, 64'd0);
        chk("reset busy", busy0, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        // Single-cycle en pulse, done 3 cycles after start; latency WORDS+1
        done_delay = 3;
        dut_out    = 40'hFF_0000_0001;
        s_before   = nstarts;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        k = 1;
        while (!st0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("start latency", 64'(k), 64'(WORDS + 1));
        wait_idle(50);
        chk("run1 dut_in", in0, 64'h00000001_00000002);
        chk("run1 run_cnt", cnt0, 16'd1);
        chk("run1 sig", sig0, 32'h0000_00FE);
        chk("run1 one start", 64'(nstarts - s_before), 64'd1);

        // Second capture of the same response
        pulse_en();
        wait_idle(50);
        chk("run2 sig", sig0, 32'h0000_0102);
        chk("run2 dut_in", in0, 64'h00000004_00000008);

        // Back-to-back runs with en held high
        dut_out = 40'h12_3456_789A;
        en = 1'b1;
        k = 0;
        while (cnt0 != 16'd16 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("reach 16 runs", cnt0, 16'd16);
        en = 1'b0;
        wait_idle(50);
        chk("b2b period", 64'(period), 64'((WORDS + 5) * 10));
        chk("run17 dut_in (lfsr 32 steps)", in0, 64'h00400007_0080000E);
        chk("run17 count", cnt0, 16'd17);
        chk("run17 starts", 64'(nstarts), 64'd17);

        // Timeout: done never arrives
        done_delay = -1;
        dut_out    = 40'h01_0000_0000;
        pulse_en();
        wait_idle(60);
        chk("timeout set", to0, 1'b1);
        chk("timeout capture time", 64'(t_idle - t_start), 64'((TIMEOUT + 2) * 10));
        done_delay = 3;
        pulse_en();
        wait_idle(50);
        chk("timeout sticky", to0, 1'b1);

        // Run counter wrap
        force dut0.run_cnt_q = 16'hFFFF;
        force dut1.run_cnt_q = 16'hFFFF;
        m_cnt = 16'hFFFF;
        @(negedge clk);
        release dut0.run_cnt_q;
        release dut1.run_cnt_q;
        chk("forced count", cnt0, 16'hFFFF);
        pulse_en();
        wait_idle(50);
        chk("count wrap", cnt0, 16'h0000);

        // Asynchronous reset while in WAIT
        done_delay = -1;
        pulse_en();
        k = 0;
        while (!st0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async rst sig", sig0, 32'd0);
        chk("async rst cnt", cnt0, 16'd0);
        chk("async rst timeout", to0, 1'b0);
        chk("async rst busy", busy0, 1'b0);
        chk("async rst start", st0, 1'b0);
        chk("async rst dut_in", in0, 64'd0);
        s_before = nstarts;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("no spurious start", 64'(nstarts), 64'(s_before));

        // done coincides with the timeout limit: done wins
        done_delay = TIMEOUT;
        dut_out    = 40'hFF_0000_0001;
        pulse_en();
        wait_idle(60);
        chk("coincide timeout clear", to0, 1'b0);
        chk("restart from seed", in0, 64'h00000001_00000002);
        chk("post-reset sig", sig0, 32'h0000_00FE);
        chk("post-reset cnt", cnt0, 16'd1);

        // done held high, including through START
        done_delay = 99;
        dut_out    = 40'hA5_5A5A_5A5A;
        pulse_en();
        wait_idle(50);
        chk("done-high cnt", cnt0, 16'd2);
        chk("done-high timeout", to0, 1'b0);
        done_delay = -1;

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
`default_nettype wire
